seven_seg_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for the 8-digit common-anode seven-segment display. Holds a frame of 8 hex nibbles plus per-digit enable and decimal-point bits. Steps through the digits one at a time, inserting a blanking dead-time between digits. Drives the existing hex-to-segment decoder with an active-high nibble, digit select and dp; the decoder performs the segment encoding and the active-low inversion.

---
 rtl/seven_seg_scan_ctrl_pkg.sv | 26 ++
 rtl/seven_seg_scan_ctrl_if.sv | 16 +
 rtl/seven_seg_slot_timer.sv | 30 +++
 rtl/seven_seg_scan_ctrl.sv | 129 ++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: display widths,
// FSM state encoding, frame payload and the nibble-slicing helper.
package seven_seg_scan_ctrl_pkg;

  localparam int unsigned MAX_DIG = 8;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned DATA_W  = MAX_DIG * NIB_W;
  localparam int unsigned IDX_W   = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [MAX_DIG-1:0] den;
    logic [MAX_DIG-1:0] dp;
  } frame_t;

  // Nibble for digit idx; digit 0 sits in the least significant bits.
  function automatic logic [NIB_W-1:0] nib_of(input logic [DATA_W-1:0] data,
                                               input logic [IDX_W-1:0]  idx);
    return data[NIB_W*32'(idx) +: NIB_W];
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Frame-update handshake between a frame producer and the scan controller.
interface seven_seg_scan_ctrl_if;

  logic [seven_seg_scan_ctrl_pkg::DATA_W-1:0]  upd_data;
  logic [seven_seg_scan_ctrl_pkg::MAX_DIG-1:0] upd_den;
  logic [seven_seg_scan_ctrl_pkg::MAX_DIG-1:0] upd_dp;
  logic                                        upd_valid;
  logic                                        upd_ready;

  modport master (output upd_data, output upd_den, output upd_dp,
                  output upd_valid, input upd_ready);

  modport slave  (input upd_data, input upd_den, input upd_dp,
                  input upd_valid, output upd_ready);

endinterface

// File: rtl/seven_seg_slot_timer.sv
// Per-digit slot counter: blank strobe at the end of the dead-time, slot
// strobe at the end of the show phase.
module seven_seg_slot_timer #(
  parameter int unsigned CLK_DIV   = 100000,
  parameter int unsigned BLANK_CYC = 16,
  parameter int unsigned CNT_W     = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic [CNT_W-1:0] cnt,
  output logic             blank_done_c,
  output logic             slot_done_c
);

  assign blank_done_c = (cnt == CNT_W'(BLANK_CYC - 1));
  assign slot_done_c  = (cnt == CNT_W'(CLK_DIV - 1));

  // Counter holds at zero whenever the scan is stopped.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt <= '0;
    end else if (slot_done_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit seven-segment display:
// shadow frame, blank/show slot sequencing and the frame-update handshake.
module seven_seg_scan_ctrl
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIG   = 8,
  parameter int unsigned CLK_DIV   = 100000,
  parameter int unsigned BLANK_CYC = 16,
  parameter int unsigned CNT_W     = 17
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  seven_seg_scan_ctrl_if.slave bus,
  output logic [NIB_W-1:0]    nibble,
  output logic [MAX_DIG-1:0]  an_sel,
  output logic                dp_in,
  output logic                frame_done
);

  logic [1:0]         state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  frame_t             shadow, shadow_n;
  logic [CNT_W-1:0]   cnt;
  logic               blank_done_c, slot_done_c;
  logic               run_c, upd_ready_c, upd_take_c;
  logic [NIB_W-1:0]   nibble_n;
  logic [MAX_DIG-1:0] an_sel_n;
  logic               dp_in_n, frame_done_n;

  // A new frame is only taken while idle or on the very first cycle of a frame.
  assign upd_ready_c   = !rst && ((state == ST_IDLE) ||
                                  (state == ST_BLANK && idx == '0 && cnt == '0));
  assign bus.upd_ready = upd_ready_c;
  assign upd_take_c    = bus.upd_valid && upd_ready_c;
  assign run_c         = enable && (state != ST_IDLE);

  seven_seg_slot_timer #(
    .CLK_DIV  (CLK_DIV),
    .BLANK_CYC(BLANK_CYC),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .run         (run_c),
    .cnt         (cnt),
    .blank_done_c(blank_done_c),
    .slot_done_c (slot_done_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      shadow     <= '0;
      nibble     <= '0;
      an_sel     <= '0;
      dp_in      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      shadow     <= shadow_n;
      nibble     <= nibble_n;
      an_sel     <= an_sel_n;
      dp_in      <= dp_in_n;
      frame_done <= frame_done_n;
    end
  end

  // Next state, shadow load, and outputs derived from the state being entered.
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    shadow_n     = shadow;
    frame_done_n = 1'b0;
    nibble_n     = '0;
    an_sel_n     = '0;
    dp_in_n      = 1'b0;

    if (upd_take_c) begin
      shadow_n = '{data: bus.upd_data, den: bus.upd_den, dp: bus.upd_dp};
    end

    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_n = ST_BLANK;
          idx_n   = '0;
        end
      end
      ST_BLANK: begin
        if (!enable) begin
          state_n = ST_IDLE;
          idx_n   = '0;
        end else if (blank_done_c) begin
          state_n = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (!enable) begin
          state_n = ST_IDLE;
          idx_n   = '0;
        end else if (slot_done_c) begin
          state_n = ST_BLANK;
          if (idx == IDX_W'(NUM_DIG - 1)) begin
            idx_n        = '0;
            frame_done_n = 1'b1;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        idx_n   = '0;
      end
    endcase

    if (state_n != ST_IDLE) begin
      nibble_n = nib_of(shadow_n.data, idx_n);
    end
    if (state_n == ST_SHOW) begin
      an_sel_n[idx_n] = shadow_n.den[idx_n];
      dp_in_n         = shadow_n.dp[idx_n] & shadow_n.den[idx_n];
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: fixed vector table, directed corner sequences
// and randomized traffic against a slot-arithmetic reference model.
module tb_seven_seg_scan_ctrl;

  localparam int ND    = 8;
  localparam int CD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * CD;

  logic       clk = 1'b0;
  logic       rst, enable;
  logic [3:0] nibble;
  logic [7:0] an_sel;
  logic       dp_in, frame_done;

  seven_seg_scan_ctrl_if bus();

  seven_seg_scan_ctrl #(
    .NUM_DIG(ND), .CLK_DIV(CD), .BLANK_CYC(BC), .CNT_W(3)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .bus(bus),
    .nibble(nibble), .an_sel(an_sel), .dp_in(dp_in), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model: scan position is just a cycle count since the scan started
  bit          m_run;
  int          m_k;
  logic [31:0] m_data;
  logic [7:0]  m_den, m_dp;

  // stimulus held between steps
  logic        s_rst, s_en, s_valid;
  logic [31:0] s_data;
  logic [7:0]  s_den, s_dp;
  logic        last_rdy, last_acc;
  int          cnt_fd, cnt_an_even;

  function automatic logic m_ready(input logic r);
    return !r && (!m_run || (m_k % FRAME) == 0);
  endfunction

  function automatic logic [13:0] m_out();
    int dig, ph;
    logic [3:0] nb;
    logic [7:0] an;
    logic dpv, fd;
    nb = 4'h0; an = 8'h00; dpv = 1'b0; fd = 1'b0;
    if (m_run) begin
      dig = (m_k / CD) % ND;
      ph  = m_k % CD;
      nb  = m_data[dig*4 +: 4];
      if (ph >= BC && m_den[dig]) begin
        an  = 8'(1 << dig);
        dpv = m_dp[dig];
      end
      fd = (m_k > 0) && ((m_k % FRAME) == 0);
    end
    return {nb, an, dpv, fd};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
  endtask

  // one clock: drive at negedge, check ready, model the edge, check outputs
  task automatic step();
    logic exp_rdy;
    rst           = s_rst;
    enable        = s_en;
    bus.upd_valid = s_valid;
    bus.upd_data  = s_data;
    bus.upd_den   = s_den;
    bus.upd_dp    = s_dp;
    #1;
    exp_rdy  = m_ready(s_rst);
    last_rdy = bus.upd_ready;
    check("upd_ready", 32'(last_rdy), 32'(exp_rdy));
    @(posedge clk);
    last_acc = s_valid && exp_rdy;
    if (s_rst) begin
      m_run = 0; m_k = 0; m_data = '0; m_den = '0; m_dp = '0;
    end else begin
      if (last_acc) begin
        m_data = s_data; m_den = s_den; m_dp = s_dp;
      end
      if (!s_en) begin
        m_run = 0; m_k = 0;
      end else if (!m_run) begin
        m_run = 1; m_k = 0;
      end else begin
        m_k++;
      end
    end
    @(negedge clk);
    check("outputs{nib,an,dp,fd}", 32'({nibble, an_sel, dp_in, frame_done}), 32'(m_out()));
    if (frame_done) cnt_fd++;
    if ((an_sel & 8'h55) != 8'h00) cnt_an_even++;
  endtask

  task automatic run_to(input int target);
    bit found = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      if (m_run && (m_k % FRAME) == target) begin
        found = 1;
        break;
      end
    end
    check("reach_position", 32'(found), 32'd1);
  endtask

  task automatic offer(input logic [31:0] d, input logic [7:0] de, input logic [7:0] dpv,
                       output int waited);
    bit got = 0;
    s_valid = 1; s_data = d; s_den = de; s_dp = dpv;
    waited = 0;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      step();
      waited++;
      if (last_acc) begin
        got = 1;
        break;
      end
    end
    s_valid = 0;
    check("frame_accepted", 32'(got), 32'd1);
  endtask

  typedef struct {
    logic r, en, v;
    logic [31:0] d;
    logic [7:0] de, dpv;
    logic x_rdy;
    logic [3:0] x_nib;
    logic [7:0] x_an;
    logic x_dp, x_fd;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;

    // reset, upload in IDLE, enable, then first slot of digit 0 and start of digit 1
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'h76543210, 8'hFF, 8'h01, 1'b1, 4'h0, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'h0, 8'h00, 8'h00, 1'b1, 4'h0, 8'h00, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h0, 8'h00, 8'h00, 1'b1, 4'h0, 8'h00, 1'b0, 1'b0};
    for (int i = 4; i < 10; i++)
      tbl[i] = '{1'b0, 1'b1, 1'b0, 32'h0, 8'h00, 8'h00, 1'b0, 4'h0, 8'h01, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0, 8'h00, 8'h00, 1'b0, 4'h1, 8'h00, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h0, 8'h00, 8'h00, 1'b0, 4'h1, 8'h00, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 32'h0, 8'h00, 8'h00, 1'b0, 4'h1, 8'h02, 1'b0, 1'b0};

    m_run = 0; m_k = 0; m_data = '0; m_den = '0; m_dp = '0;
    s_rst = 1; s_en = 0; s_valid = 0; s_data = '0; s_den = '0; s_dp = '0;
    cnt_fd = 0; cnt_an_even = 0;
    @(negedge clk);

    // empty shadow: scan runs dark, frame_done every FRAME cycles
    step();
    s_rst = 0; s_en = 1;
    cnt_fd = 0;
    for (int i = 0; i < 2 * FRAME + 2; i++) step();
    check("dark_frame_done_count", 32'(cnt_fd), 32'd2);
    check("dark_an_sel_even", 32'(cnt_an_even), 32'd0);

    for (int i = 0; i < 13; i++) begin
      s_rst = tbl[i].r; s_en = tbl[i].en; s_valid = tbl[i].v;
      s_data = tbl[i].d; s_den = tbl[i].de; s_dp = tbl[i].dpv;
      step();
      check($sformatf("tbl%0d_ready", i), 32'(last_rdy), 32'(tbl[i].x_rdy));
      check($sformatf("tbl%0d_out", i), 32'({nibble, an_sel, dp_in, frame_done}),
            32'({tbl[i].x_nib, tbl[i].x_an, tbl[i].x_dp, tbl[i].x_fd}));
    end
    s_valid = 0;
    for (int i = 0; i < FRAME + 20; i++) step();

    // update offered at digit 3 waits for the next frame start
    run_to(3 * CD);
    offer(32'hFFFF_FFFF, 8'hFF, 8'h00, waited);
    check("midframe_wait_cycles", 32'(waited), 32'(FRAME - 3 * CD + 1));
    for (int i = 0; i < FRAME; i++) step();

    // odd digits only: even anodes never light, frame timing unchanged
    offer(32'hA5C3_1E7B, 8'hAA, 8'hFF, waited);
    cnt_fd = 0; cnt_an_even = 0;
    for (int i = 0; i < 2 * FRAME; i++) step();
    check("odd_only_even_an", 32'(cnt_an_even), 32'd0);
    check("odd_only_frame_done", 32'(cnt_fd), 32'd2);

    // enable dropped during SHOW of digit 5, then re-enabled
    run_to(5 * CD + BC + 1);
    s_en = 0;
    step();
    check("disable_an_sel", 32'(an_sel), 32'd0);
    for (int i = 0; i < 5; i++) step();
    check("disabled_ready", 32'(last_rdy), 32'd1);
    s_en = 1;
    for (int i = 0; i < FRAME + 4; i++) step();

    // reset during SHOW of digit 2 clears outputs and shadow
    run_to(2 * CD + BC + 1);
    s_rst = 1;
    step();
    check("rst_outputs", 32'({nibble, an_sel, dp_in, frame_done}), 32'd0);
    s_rst = 0;
    step();
    step();
    check("post_rst_blank_nibble", 32'(nibble), 32'd0);
    for (int i = 0; i < BC; i++) step();
    check("post_rst_show_an", 32'(an_sel), 32'd0);
    for (int i = 0; i < FRAME; i++) step();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      s_rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) == 0) s_en = ~s_en;
      if (!s_valid && $urandom_range(0, 39) == 0) begin
        s_valid = 1;
        s_data  = $urandom;
        s_den   = 8'($urandom);
        s_dp    = 8'($urandom);
      end
      step();
      if (last_acc) s_valid = 0;
      if (!s_en && $urandom_range(0, 9) == 0) s_en = 1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
